// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD engine: default widths and the controller
// state encoding used by gcd_engine.
// -----------------------------------------------------------------------------
package gcd_pkg;

    // Default operand/result width and iteration counter width.
    localparam int GCD_W_DEFAULT     = 8;
    localparam int GCD_CNT_W_DEFAULT = GCD_W_DEFAULT;

    // Controller states.
    localparam int GCD_STATE_W = 2;

    typedef enum logic [GCD_STATE_W-1:0] {
        GCD_IDLE = 2'd0,
        GCD_CALC = 2'd1,
        GCD_DONE = 2'd2
    } gcd_state_e;

    // Plain-vector aliases of the same encoding for code that keeps the
    // state register as a bare logic vector.
    localparam logic [GCD_STATE_W-1:0] ST_IDLE = GCD_IDLE;
    localparam logic [GCD_STATE_W-1:0] ST_CALC = GCD_CALC;
    localparam logic [GCD_STATE_W-1:0] ST_DONE = GCD_DONE;

endpackage : gcd_pkg

// File: rtl/gcd_if.sv
// -----------------------------------------------------------------------------
// gcd_if
// Request/response bundle between a GCD requester and gcd_engine.
//   start  : request, honoured only while ready is high
//   A, B   : unsigned operands, captured on accept
//   ready  : engine idle and able to accept
//   busy   : engine iterating
//   done   : one-cycle completion pulse
//   res    : GCD result, held until the next completion
//   iter   : subtract steps used for res (saturating)
//   err    : both operands were zero
// Modports: master (requester side), slave (engine side).
// -----------------------------------------------------------------------------
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W_DEFAULT,
    parameter int CNT_W = W
);

    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [W-1:0]     res;
    logic [CNT_W-1:0] iter;
    logic             err;

    modport master (
        output start, A, B,
        input  ready, busy, done, res, iter, err
    );

    modport slave (
        input  start, A, B,
        output ready, busy, done, res, iter, err
    );

endinterface : gcd_if

// File: rtl/gcd_step.sv
// -----------------------------------------------------------------------------
// gcd_step
// One combinational step of the subtractive Euclid algorithm.
//   a, b    : current operand pair
//   eq      : a == b (algorithm finished, result is a)
//   a_next  : a - b when a > b, otherwise a
//   b_next  : b - a when b > a, otherwise b
// Only the larger operand is reduced, so neither result can underflow.
// -----------------------------------------------------------------------------
module gcd_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic [W-1:0] a_next,
    output logic [W-1:0] b_next
);

    assign eq     = (a == b);
    assign a_next = (a > b) ? (a - b) : a;
    assign b_next = (b > a) ? (b - a) : b;

endmodule : gcd_step

// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
// Iterative GCD of two unsigned W-bit operands by repeated subtraction.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous reset, active low
//   bus : gcd_if slave port (start/A/B in; ready/busy/done/res/iter/err out)
// Flow: IDLE --accept--> CALC --a==b--> DONE --> IDLE.
// Operands containing a zero skip CALC and complete in a single cycle.
// res/iter/err are only updated on entry to DONE and held afterwards.
// -----------------------------------------------------------------------------
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W_DEFAULT,
    parameter int CNT_W = W
) (
    input logic  clk,
    input logic  rst,
    gcd_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [GCD_STATE_W-1:0] state_q, state_d;
    logic [W-1:0]           a_q, a_d;
    logic [W-1:0]           b_q, b_d;
    logic [W-1:0]           res_q, res_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       iter_q, iter_d;
    logic                   err_q, err_d;

    logic                   step_eq;
    logic [W-1:0]           step_a;
    logic [W-1:0]           step_b;
    logic                   a_nz;
    logic                   b_nz;

    gcd_step #(
        .W (W)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .eq     (step_eq),
        .a_next (step_a),
        .b_next (step_b)
    );

    assign a_nz = (bus.A != '0);
    assign b_nz = (bus.B != '0);

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    if (a_nz && b_nz) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        state_d = ST_CALC;
                    end else begin
                        // At most one operand is non-zero here, so OR-ing
                        // them yields that operand (or 0 when both are 0).
                        res_d   = bus.A | bus.B;
                        iter_d  = '0;
                        err_d   = !a_nz && !b_nz;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_CALC: begin
                if (step_eq) begin
                    res_d   = a_q;
                    iter_d  = cnt_q;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    // Saturate rather than wrap when CNT_W is too narrow.
                    cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all sequential state so that
            // every register samples values from before this edge.
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.busy  = (state_q == ST_CALC);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.res   = res_q;
    assign bus.iter  = iter_q;
    assign bus.err   = err_q;

endmodule : gcd_engine
